// File: rtl/system_cpu_mul_seq.sv
// rtl/system_cpu_mul_seq.sv - sequential 32x32 multiplier built on one shared 16x16 multiplier
// Optional signed high-word corrections are enabled by defining SYSTEM_CPU_MUL_SEQ_SIGNED_EN.
module system_cpu_mul_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_CORR  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_cnt;
  logic [63:0] r_acc;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [1:0]  r_op;
  logic [31:0] r_pp;
  logic        r_pp_vld;
  logic [1:0]  r_pp_cnt;
  logic        r_done;
  logic [31:0] r_result;

  logic [15:0] w_mul_a;
  logic [15:0] w_mul_b;
  logic [31:0] w_mul_p;
  logic [63:0] w_pp_shifted;
  logic [63:0] w_acc_sum;
  logic [63:0] w_acc_corr;

  // cnt bit 1 picks the a half, bit 0 the b half: lo*lo, lo*hi, hi*lo, hi*hi
  assign w_mul_a = r_cnt[1] ? r_a[31:16] : r_a[15:0];
  assign w_mul_b = r_cnt[0] ? r_b[31:16] : r_b[15:0];
  assign w_mul_p = {16'd0, w_mul_a} * {16'd0, w_mul_b};

  always_comb begin
    w_pp_shifted = 64'd0;
    case (r_pp_cnt)
      2'd0:    w_pp_shifted = {32'd0, r_pp};
      2'd3:    w_pp_shifted = {r_pp, 32'd0};
      default: w_pp_shifted = {16'd0, r_pp, 16'd0};
    endcase
  end

  assign w_acc_sum = r_pp_vld ? (r_acc + w_pp_shifted) : r_acc;

`ifdef SYSTEM_CPU_MUL_SEQ_SIGNED_EN
  // Unsigned product minus 2^32 times the other operand for each negative signed input
  logic [63:0] w_corr_a;
  logic [63:0] w_corr_b;
  assign w_corr_a   = (r_op[1] && r_a[31]) ? {r_b, 32'd0} : 64'd0;
  assign w_corr_b   = ((r_op == 2'b11) && r_b[31]) ? {r_a, 32'd0} : 64'd0;
  assign w_acc_corr = r_acc - w_corr_a - w_corr_b;
`else
  assign w_acc_corr = r_acc;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_ISSUE;
      S_ISSUE: if (r_cnt == 2'd3) w_state_nxt = S_DRAIN;
      S_DRAIN: w_state_nxt = S_CORR;
      S_CORR:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt    <= 2'd0;
      r_acc    <= 64'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_op     <= 2'd0;
      r_pp     <= 32'd0;
      r_pp_vld <= 1'b0;
      r_pp_cnt <= 2'd0;
      r_done   <= 1'b0;
      r_result <= 32'd0;
    end else begin
      r_done   <= 1'b0;
      r_pp_vld <= (r_state == S_ISSUE);
      r_pp_cnt <= r_cnt;
      if (r_state == S_ISSUE) r_pp <= w_mul_p;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a   <= src1;
            r_b   <= src2;
            r_op  <= op;
            r_acc <= 64'd0;
            r_cnt <= 2'd0;
          end
        end
        S_ISSUE: begin
          r_cnt <= r_cnt + 2'd1;
          r_acc <= w_acc_sum;
        end
        S_DRAIN: begin
          r_acc <= w_acc_sum;
        end
        S_CORR: begin
          r_acc    <= w_acc_corr;
          r_result <= (r_op == 2'b00) ? w_acc_corr[31:0] : w_acc_corr[63:32];
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_system_cpu_mul_seq.sv
// tb/tb_system_cpu_mul_seq.sv - scoreboard bench for system_cpu_mul_seq
// Honours SYSTEM_CPU_MUL_SEQ_SIGNED_EN the same way as the design.
module tb_system_cpu_mul_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] src1 = 32'd0;
  logic [31:0] src2 = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  system_cpu_mul_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .src1    (src1),
    .src2    (src2),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;
  exp_t scb[$];

  function automatic logic [31:0] ref_mul(input logic [1:0] f_op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    logic        sa;
    logic        sbit;
    sa   = 1'b0;
    sbit = 1'b0;
`ifdef SYSTEM_CPU_MUL_SEQ_SIGNED_EN
    sa   = f_op[1];
    sbit = (f_op == 2'b11);
`endif
    ea = (sa && a[31]) ? {32'hFFFFFFFF, a} : {32'd0, a};
    eb = (sbit && b[31]) ? {32'hFFFFFFFF, b} : {32'd0, b};
    p  = ea * eb;
    return (f_op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drives a start request now; it is sampled on the next rising edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit expect_done);
    exp_t e;
    op    = o;
    src1  = a;
    src2  = b;
    start = 1'b1;
    if (expect_done) begin
      e.res = ref_mul(o, a, b);
      e.due = cyc + 7;
      scb.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 2'($urandom);
    src1  = $urandom;
    src2  = $urandom;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL wait_idle_timeout actual=busy required=idle");
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (scb.size() != 0 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (scb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0", scb.size());
    end
  endtask

  exp_t        mon_e;
  logic [31:0] last_res = 32'd0;
  logic        rst_edge = 1'b0;
  always @(posedge clk) rst_edge <= reset_n;

  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (scb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done actual=done result=%h cycle=%0d required=no_done", result, cyc);
      end else begin
        mon_e = scb.pop_front();
        checks++;
        if (result !== mon_e.res) begin
          errors++;
          $display("FAIL result actual=%h expected=%h cycle=%0d", result, mon_e.res, cyc);
        end
        checks++;
        if (cyc != mon_e.due) begin
          errors++;
          $display("FAIL latency actual_cycle=%0d expected_cycle=%0d", cyc, mon_e.due);
        end
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL busy_at_done actual=%b expected=0", busy);
      end
      last_res = result;
    end else if (!rst_edge) begin
      last_res = result;
    end else begin
      checks++;
      if (result !== last_res) begin
        errors++;
        $display("FAIL result_hold actual=%h expected=%h cycle=%0d", result, last_res, cyc);
      end
    end
  end

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'h00000000;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'h00000000);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    issue(2'b00, 32'h00012345, 32'h00010000, 1'b1);
    wait_drain();
    chk("mul_low_shift", result, 32'h23450000);

    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    wait_drain();
    chk("mulxuu_ones", result, 32'hFFFFFFFE);

    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    wait_drain();
    chk("mul_ones", result, 32'h00000001);

    issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    wait_drain();
`ifdef SYSTEM_CPU_MUL_SEQ_SIGNED_EN
    chk("mulxss_ones", result, 32'h00000000);
`else
    chk("mulxss_ones", result, 32'hFFFFFFFE);
`endif

    issue(2'b10, 32'hFFFFFFFF, 32'h00000002, 1'b1);
    wait_drain();
`ifdef SYSTEM_CPU_MUL_SEQ_SIGNED_EN
    chk("mulxsu_neg", result, 32'hFFFFFFFF);
`else
    chk("mulxsu_neg", result, 32'h00000001);
`endif

    // start while busy must be ignored
    issue(2'b01, 32'h12345678, 32'h9ABCDEF0, 1'b1);
    @(posedge clk);
    #1;
    op    = 2'b00;
    src1  = 32'h00000003;
    src2  = 32'h00000005;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_drain();
    repeat (8) @(posedge clk);
    #1;

    // back-to-back: start raised inside the done cycle
    issue(2'b00, 32'hDEADBEEF, 32'h00000011, 1'b1);
    for (int n = 0; n < 20 && !done; n++) @(negedge clk);
    chk("b2b_done_seen", {31'd0, done}, 32'd1);
    issue(2'b11, 32'h80000001, 32'hC0000003, 1'b1);
    wait_drain();

    // reset in cycle 3 of an operation aborts it
    issue(2'b01, 32'hFFFF0000, 32'h0000FFFF, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", result, 32'h00000000);
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_result_hold", result, 32'h00000000);
    issue(2'b10, 32'h80000000, 32'h00000003, 1'b1);
    wait_drain();

    for (int i = 0; i < 40; i++) begin
      wait_idle();
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      issue(2'($urandom), pick_operand(), pick_operand(), 1'b1);
    end
    wait_drain();
    repeat (4) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
